// File: rtl/cpu_rom_fetch.sv
// cpu_rom_fetch
//   Instruction-fetch adapter between the CPU instruction bus and the boot ROM
//   (1024x32 synchronous-read array with registered output). Byte-addressed
//   fetch requests are accepted with a valid/ready handshake. The ROM word
//   address is driven straight from the request address. The ROM word that
//   comes back one cycle later is captured into a small in-order response
//   FIFO, which absorbs core backpressure. A flush discards everything
//   pending except a request that fires in the flush cycle itself.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   flush_i      drop pending/in-flight responses (branch redirect)
//   req_valid_i  fetch request valid
//   req_ready_o  fetch request accepted when valid & ready
//   req_addr_i   fetch byte address
//   rsp_valid_o  response valid
//   rsp_ready_i  core accepts response
//   rsp_data_o   instruction word (0 on error)
//   rsp_err_o    access fault (misaligned or outside the ROM window)
//   rom_addr_o   ROM word address (combinational from req_addr_i)
//   rom_q_i      ROM read data

module cpu_rom_fetch #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter int          FIFO_DEPTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_addr_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_q_i
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  // ROM window size in bytes; one extra bit so 4*2**ADDR_WIDTH never truncates.
  localparam logic [32:0] WIN_BYTES = 33'd4 << ADDR_WIDTH;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
  } rsp_t;

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic          inflight_q, inflight_d;   // a request fired last cycle
  logic          ierr_q, ierr_d;           // its fault flag
  rsp_t          mem_q [FIFO_DEPTH];
  rsp_t          mem_d [FIFO_DEPTH];
  rsp_t          head_q, head_d;           // registered copy of the head entry

  logic [31:0] offs;
  logic        req_err;
  logic        fire;
  logic        push;
  logic        pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  assign rom_addr_o = req_addr_i[ADDR_WIDTH+1:2];

  // Unsigned offset: addresses below BASE_ADDR wrap high and fault.
  assign offs    = req_addr_i - BASE_ADDR;
  assign req_err = (req_addr_i[1:0] != 2'b00) | ({1'b0, offs} >= WIN_BYTES);

  // Entries in the FIFO plus the one in flight reserve a slot, so a push can
  // never overflow. Only registered state feeds this (plus reset gating).
  assign req_ready_o = rst_ni & ((int'(count_q) + int'(inflight_q)) < FIFO_DEPTH);
  assign fire        = req_valid_i & req_ready_o;

  // ---------------------------------------------------------------------------
  // Response side
  // ---------------------------------------------------------------------------
  assign rsp_valid_o = (count_q != '0) & ~flush_i;
  assign pop         = rsp_valid_o & rsp_ready_i;
  // Flush kills the in-flight word that would land this cycle.
  assign push        = inflight_q & ~flush_i;

  assign rsp_data_o  = head_q.data;
  assign rsp_err_o   = head_q.err;

  always_comb begin
    count_d    = count_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    mem_d      = mem_q;
    head_d     = head_q;
    inflight_d = fire;
    ierr_d     = req_err;

    if (flush_i) begin
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q].data = ierr_q ? '0 : rom_q_i;
        mem_d[wptr_q].err  = ierr_q;
        wptr_d             = ptr_inc(wptr_q);
      end
      if (pop) rptr_d = ptr_inc(rptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Head register tracks the next-state head; it holds when empty.
    if (count_d != '0) head_d = mem_d[rptr_d];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      inflight_q <= 1'b0;
      ierr_q     <= 1'b0;
      head_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q    <= count_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      inflight_q <= inflight_d;
      ierr_q     <= ierr_d;
      head_q     <= head_d;
      mem_q      <= mem_d;
    end
  end

endmodule
